// File: rtl/regfile_port_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_port_ctrl
//
// Purpose:
//   Sequencing initiator for a small nibble register file. It takes one
//   single-beat host request at a time over a valid/ready channel, turns it
//   into a timed write pulse or read window on the register file pins, and
//   returns exactly one response per request over a valid/ready channel.
//   The write and read enables are never high in the same cycle.
//
// Optional feature (compile-time macro REGFILE_WRITE_VERIFY_EN):
//   When defined, every write is followed by a read-back of the same address
//   (VERIFY state). The read-back value is returned in o_rsp_rdata, and
//   o_rsp_err flags a mismatch against the written data. When undefined,
//   write responses carry o_rsp_rdata = 0 and o_rsp_err is always 0.
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_req_valid     request present
//   o_req_ready     controller can accept a request (state == IDLE)
//   i_req_write     1 = write, 0 = read
//   i_req_addr      target register
//   i_req_wdata     write data
//   o_rsp_valid     response present
//   i_rsp_ready     host accepts the response
//   o_rsp_rdata     read data / verify read-back data
//   o_rsp_err       write-verify mismatch
//   o_rf_data_in    register file data_in
//   o_rf_write_add  register file write_add
//   o_rf_write_en   register file write_en
//   o_rf_read_add   register file read_add
//   o_rf_read_en    register file read_en
//   i_rf_data_out   register file data_out (shared bus)
//
// Parameters:
//   ADDR_W       register file address width
//   DATA_W       register data width
//   WRITE_PULSE  cycles o_rf_write_en is held high per write (>= 1)
//   READ_WAIT    cycles o_rf_read_en is held high before sampling (>= 1)
// ---------------------------------------------------------------------------
module regfile_port_ctrl #(
    parameter int ADDR_W      = 2,
    parameter int DATA_W      = 4,
    parameter int WRITE_PULSE = 1,
    parameter int READ_WAIT   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [DATA_W-1:0] o_rf_data_in,
    output logic [ADDR_W-1:0] o_rf_write_add,
    output logic              o_rf_write_en,
    output logic [ADDR_W-1:0] o_rf_read_add,
    output logic              o_rf_read_en,
    input  logic [DATA_W-1:0] i_rf_data_out
);

    // Counter sized for the longer of the two windows; it is loaded with
    // (window - 1) on state entry and counts down to zero, never wrapping.
    localparam int MAX_WAIT = (WRITE_PULSE > READ_WAIT) ? WRITE_PULSE : READ_WAIT;
    localparam int CNT_W    = $clog2(MAX_WAIT) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] WP_LOAD  = CNT_W'(WRITE_PULSE - 1);
    localparam logic [CNT_W-1:0] RW_LOAD  = CNT_W'(READ_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_READ   = 3'd2,
        S_RESP   = 3'd3
`ifdef REGFILE_WRITE_VERIFY_EN
        ,
        S_VERIFY = 3'd4
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    // Registered outputs and their next-state values. The rf address/data
    // registers double as the latched request: they are loaded on accept and
    // hold their value until the next request of the same kind.
    logic [DATA_W-1:0] r_rf_data_in;
    logic [DATA_W-1:0] w_rf_data_in_nxt;
    logic [ADDR_W-1:0] r_rf_write_add;
    logic [ADDR_W-1:0] w_rf_write_add_nxt;
    logic              r_rf_write_en;
    logic              w_rf_write_en_nxt;
    logic [ADDR_W-1:0] r_rf_read_add;
    logic [ADDR_W-1:0] w_rf_read_add_nxt;
    logic              r_rf_read_en;
    logic              w_rf_read_en_nxt;
    logic              r_rsp_valid;
    logic              w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [DATA_W-1:0] w_rsp_rdata_nxt;
    logic              r_rsp_err;
    logic              w_rsp_err_nxt;

    // State and window counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter and next-output logic for the sequencing FSM.
    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_rf_data_in_nxt   = r_rf_data_in;
        w_rf_write_add_nxt = r_rf_write_add;
        w_rf_write_en_nxt  = r_rf_write_en;
        w_rf_read_add_nxt  = r_rf_read_add;
        w_rf_read_en_nxt   = r_rf_read_en;
        w_rsp_valid_nxt    = r_rsp_valid;
        w_rsp_rdata_nxt    = r_rsp_rdata;
        w_rsp_err_nxt      = r_rsp_err;

        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    if (i_req_write) begin
                        w_state_nxt        = S_WRITE;
                        w_cnt_nxt          = WP_LOAD;
                        w_rf_write_add_nxt = i_req_addr;
                        w_rf_data_in_nxt   = i_req_wdata;
                        w_rf_write_en_nxt  = 1'b1;
                    end else begin
                        w_state_nxt       = S_READ;
                        w_cnt_nxt         = RW_LOAD;
                        w_rf_read_add_nxt = i_req_addr;
                        w_rf_read_en_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_WRITE: begin
                if (r_cnt == CNT_ZERO) begin
                    w_rf_write_en_nxt = 1'b0;
`ifdef REGFILE_WRITE_VERIFY_EN
                    // Read-back starts on the same edge the write pulse ends,
                    // so the two enables never overlap.
                    w_state_nxt       = S_VERIFY;
                    w_cnt_nxt         = RW_LOAD;
                    w_rf_read_add_nxt = r_rf_write_add;
                    w_rf_read_en_nxt  = 1'b1;
`else
                    w_state_nxt       = S_RESP;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_rdata_nxt   = {DATA_W{1'b0}};
                    w_rsp_err_nxt     = 1'b0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end

            S_READ: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt      = S_RESP;
                    w_rf_read_en_nxt = 1'b0;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_rdata_nxt  = i_rf_data_out;
                    w_rsp_err_nxt    = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end

`ifdef REGFILE_WRITE_VERIFY_EN
            S_VERIFY: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt      = S_RESP;
                    w_rf_read_en_nxt = 1'b0;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_rdata_nxt  = i_rf_data_out;
                    // r_rf_data_in still holds the value that was written.
                    w_rsp_err_nxt    = (i_rf_data_out != r_rf_data_in);
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
`endif

            S_RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end

            default: begin
                // Unreachable encoding: return to a safe idle condition.
                w_state_nxt       = S_IDLE;
                w_cnt_nxt         = CNT_ZERO;
                w_rf_write_en_nxt = 1'b0;
                w_rf_read_en_nxt  = 1'b0;
                w_rsp_valid_nxt   = 1'b0;
            end
        endcase
    end

    // Output registers; async reset drops both enables immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rf_data_in   <= {DATA_W{1'b0}};
            r_rf_write_add <= {ADDR_W{1'b0}};
            r_rf_write_en  <= 1'b0;
            r_rf_read_add  <= {ADDR_W{1'b0}};
            r_rf_read_en   <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= {DATA_W{1'b0}};
            r_rsp_err      <= 1'b0;
        end else begin
            r_rf_data_in   <= w_rf_data_in_nxt;
            r_rf_write_add <= w_rf_write_add_nxt;
            r_rf_write_en  <= w_rf_write_en_nxt;
            r_rf_read_add  <= w_rf_read_add_nxt;
            r_rf_read_en   <= w_rf_read_en_nxt;
            r_rsp_valid    <= w_rsp_valid_nxt;
            r_rsp_rdata    <= w_rsp_rdata_nxt;
            r_rsp_err      <= w_rsp_err_nxt;
        end
    end

    assign o_req_ready    = (r_state == S_IDLE);
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_rdata    = r_rsp_rdata;
    assign o_rsp_err      = r_rsp_err;
    assign o_rf_data_in   = r_rf_data_in;
    assign o_rf_write_add = r_rf_write_add;
    assign o_rf_write_en  = r_rf_write_en;
    assign o_rf_read_add  = r_rf_read_add;
    assign o_rf_read_en   = r_rf_read_en;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_port_ctrl
//
// Scoreboard bench: the stimulus process computes each expected response
// from a plain array model of the register file and pushes it into a queue;
// a negedge monitor pops and compares whenever a response is presented, and
// independently checks write pulse / read window lengths and enable
// exclusivity. Build with or without REGFILE_WRITE_VERIFY_EN.
// ---------------------------------------------------------------------------
module tb_regfile_port_ctrl;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;
    localparam int WP     = 2;
    localparam int RW     = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [DATA_W-1:0] rf_data_in;
    logic [ADDR_W-1:0] rf_write_add;
    logic              rf_write_en;
    logic [ADDR_W-1:0] rf_read_add;
    logic              rf_read_en;
    logic [DATA_W-1:0] rf_data_out;

    always #5 clk = ~clk;

    regfile_port_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WRITE_PULSE(WP), .READ_WAIT(RW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_write(req_write), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_rf_data_in(rf_data_in), .o_rf_write_add(rf_write_add),
        .o_rf_write_en(rf_write_en), .o_rf_read_add(rf_read_add),
        .o_rf_read_en(rf_read_en), .i_rf_data_out(rf_data_out)
    );

    // ---------------- register file model (shared bus idles at all ones)
    logic [DATA_W-1:0] rf_mem [4];
    logic              stuck_b0;

    always @(posedge clk) begin
        if (rf_write_en) rf_mem[rf_write_add] <= rf_data_in;
    end

    assign rf_data_out = rf_read_en ? (rf_mem[rf_read_add] & (stuck_b0 ? 4'hE : 4'hF)) : 4'hF;

    // ---------------- scoreboard state
    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                lat;
        int                acc_cyc;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    exp_t              exp_q[$];
    wr_t               wr_q[$];
    logic [ADDR_W-1:0] rd_q[$];
    logic [DATA_W-1:0] ref_mem [4];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rsp_mode = 0;  // 0: ready held 1, 1: random, 2: ready held 0

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // rsp_ready driver: changes only just after a rising edge.
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rsp_mode)
                1:       rsp_ready = ($urandom_range(0, 3) != 0);
                2:       rsp_ready = 1'b0;
                default: rsp_ready = 1'b1;
            endcase
        end
    end

    // ---------------- monitor
    int  wr_run     = 0;
    int  rd_run     = 0;
    bit  prev_valid = 1'b0;
    wr_t cur_wr;
    logic [ADDR_W-1:0] cur_rd;

    always @(negedge clk) begin
        if (!rst_n) begin
            wr_run     = 0;
            rd_run     = 0;
            prev_valid = 1'b0;
            exp_q.delete();
            wr_q.delete();
            rd_q.delete();
        end else begin
            chk(!(rf_write_en && rf_read_en), "enable_exclusive", {rf_write_en, rf_read_en}, 0);

            if (rf_write_en) begin
                if (wr_run == 0) begin
                    if (wr_q.size() == 0) begin
                        chk(1'b0, "unexpected_write_pulse", 1, 0);
                        cur_wr = '{a: rf_write_add, d: rf_data_in};
                    end else begin
                        cur_wr = wr_q.pop_front();
                    end
                end
                wr_run++;
                chk(rf_write_add == cur_wr.a, "write_addr", rf_write_add, cur_wr.a);
                chk(rf_data_in == cur_wr.d, "write_data", rf_data_in, cur_wr.d);
            end else if (wr_run > 0) begin
                chk(wr_run == WP, "write_pulse_len", wr_run, WP);
                wr_run = 0;
            end else begin
                wr_run = 0;
            end

            if (rf_read_en) begin
                if (rd_run == 0) begin
                    if (rd_q.size() == 0) begin
                        chk(1'b0, "unexpected_read_window", 1, 0);
                        cur_rd = rf_read_add;
                    end else begin
                        cur_rd = rd_q.pop_front();
                    end
                end
                rd_run++;
                chk(rf_read_add == cur_rd, "read_addr", rf_read_add, cur_rd);
            end else if (rd_run > 0) begin
                chk(rd_run == RW, "read_window_len", rd_run, RW);
                rd_run = 0;
            end else begin
                rd_run = 0;
            end

            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_response", 1, 0);
                end else begin
                    if (!prev_valid)
                        chk(cyc - exp_q[0].acc_cyc == exp_q[0].lat, "rsp_latency",
                            cyc - exp_q[0].acc_cyc, exp_q[0].lat);
                    chk(rsp_rdata == exp_q[0].rdata, "rsp_rdata", rsp_rdata, exp_q[0].rdata);
                    chk(rsp_err == exp_q[0].err, "rsp_err", rsp_err, exp_q[0].err);
                    chk(!req_ready, "req_ready_low_in_resp", req_ready, 0);
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
            prev_valid = rsp_valid && !rsp_ready;
        end
    end

    // ---------------- stimulus helpers
    task automatic send(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk(1'b0, "accept_timeout", n, 200);
        end else begin
            e.acc_cyc = cyc;
            e.err     = 1'b0;
            if (w) begin
                ref_mem[a] = d;
                wr_q.push_back('{a: a, d: d});
`ifdef REGFILE_WRITE_VERIFY_EN
                rd_q.push_back(a);
                e.rdata = stuck_b0 ? (d & 4'hE) : d;
                e.err   = (e.rdata != d);
                e.lat   = WP + RW + 1;
`else
                e.rdata = 4'h0;
                e.lat   = WP + 1;
`endif
            end else begin
                rd_q.push_back(a);
                e.rdata = stuck_b0 ? (ref_mem[a] & 4'hE) : ref_mem[a];
                e.lat   = RW + 1;
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(n < 500, "drain_timeout", n, 500);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk(req_ready == 1'b1, {tag, "_req_ready"}, req_ready, 1);
        chk(rsp_valid == 1'b0, {tag, "_rsp_valid"}, rsp_valid, 0);
        chk(rsp_rdata == 4'h0, {tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk(rsp_err == 1'b0, {tag, "_rsp_err"}, rsp_err, 0);
        chk(rf_write_en == 1'b0, {tag, "_write_en"}, rf_write_en, 0);
        chk(rf_read_en == 1'b0, {tag, "_read_en"}, rf_read_en, 0);
        chk(rf_write_add == 2'd0, {tag, "_write_add"}, rf_write_add, 0);
        chk(rf_read_add == 2'd0, {tag, "_read_add"}, rf_read_add, 0);
        chk(rf_data_in == 4'h0, {tag, "_data_in"}, rf_data_in, 0);
    endtask

    // ---------------- main sequence
    initial begin
        logic [DATA_W-1:0] init_data [4];
        int n;
        init_data[0] = 4'h3;
        init_data[1] = 4'h5;
        init_data[2] = 4'h9;
        init_data[3] = 4'hC;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 2'd0;
        req_wdata = 4'h0;
        stuck_b0  = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[i] = 4'h0;

        // reset with the bus idling at 4'hF
        #2;
        check_idle_outputs("in_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("after_reset");

        // single write addr 2 data A
        send(1'b1, 2'd2, 4'hA);
        drain();

        // fill all registers, then read back 3 and 1
        for (int i = 0; i < 4; i++) send(1'b1, 2'(i), init_data[i]);
        send(1'b0, 2'd3, 4'h0);
        send(1'b0, 2'd1, 4'h0);
        drain();

        // response stall: rsp_ready held low, competing request ignored
        rsp_mode = 2;
        send(1'b0, 2'd1, 4'h0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(rsp_valid, "stall_rsp_timeout", rsp_valid, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 2'd2;
        req_wdata = 4'h3;
        repeat (5) begin
            @(negedge clk);
            chk(!req_ready, "stall_req_ready", req_ready, 0);
            chk(!rf_write_en, "stall_no_write", rf_write_en, 0);
            chk(rsp_valid, "stall_rsp_valid", rsp_valid, 1);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_mode  = 0;
        drain();

        // write with a stuck-at-0 bit 0 on the read path
        stuck_b0 = 1'b1;
        send(1'b1, 2'd0, 4'h7);
        drain();
        stuck_b0 = 1'b0;

        // randomized traffic with random response back-pressure
        rsp_mode = 1;
        for (int i = 0; i < 40; i++) begin
            send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        rsp_mode = 0;
        drain();

        // reset in the second READ cycle: enable drops at once, no response
        send(1'b0, 2'd2, 4'h0);
        @(posedge clk);
        #1;
        chk(rf_read_en, "pre_reset_read_en", rf_read_en, 1);
        rst_n = 1'b0;
        #1;
        chk(!rf_read_en, "reset_read_en_drop", rf_read_en, 0);
        chk(!rsp_valid, "reset_rsp_valid", rsp_valid, 0);
        chk(req_ready, "reset_req_ready", req_ready, 1);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk(!rsp_valid, "no_rsp_after_reset", rsp_valid, 0);
            chk(req_ready, "idle_after_reset", req_ready, 1);
        end

        // controller still works after the aborted read
        send(1'b1, 2'd1, 4'h6);
        send(1'b0, 2'd1, 4'h0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_port_ctrl.md
Name: regfile_port_ctrl

Overview:
- Sequencing initiator that drives the 4x4 nibble register file's address, enable and data pins from a valid/ready request channel, and returns one response per request.
- Converts single-beat host transactions into correctly timed write pulses and read windows on the register file's shared output bus.
- Sits between a host (bus bridge or test sequencer) and the register file. It guarantees read and write enables are never high together.

Parameters:
- ADDR_W, 2, register file address width.
- DATA_W, 4, register data width.
- WRITE_PULSE, 1, cycles rf_write_en is held high per write. Must be >= 1.
- READ_WAIT, 1, cycles rf_read_en is held high before rf_data_out is sampled (bus settle). Must be >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  target register.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  host accepts the response.
- rsp_rdata  output  DATA_W  read data (see Behaviour).
- rsp_err  output  1  write-verify mismatch (optional feature).
- rf_data_in  output  DATA_W  to register file data_in.
- rf_write_add  output  ADDR_W  to register file write_add.
- rf_write_en  output  1  to register file write_en.
- rf_read_add  output  ADDR_W  to register file read_add.
- rf_read_en  output  1  to register file read_en.
- rf_data_out  input  DATA_W  from register file data_out (shared bus).

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, counter 0.
  - req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0.
  - rf_write_en = 0, rf_read_en = 0; all rf address and data outputs = 0.
- All outputs are registered, except req_ready, which is (state == IDLE).
- States: IDLE, WRITE, READ, VERIFY (optional), RESP.
- IDLE:
  - On req_valid & req_ready, latch addr, wdata and write.
  - Write: go to WRITE. rf_write_add and rf_data_in are loaded in the same edge and rf_write_en goes 1.
  - Read: go to READ. rf_read_add is loaded and rf_read_en goes 1.
- WRITE:
  - rf_write_en is held 1 for exactly WRITE_PULSE cycles, with address and data stable for that whole window.
  - Then rf_write_en goes 0 and the state moves to RESP (or VERIFY if the feature is enabled).
  - Without the feature, rsp_rdata = 0 on a write response.
- READ:
  - rf_read_en is held 1 for exactly READ_WAIT cycles.
  - At the edge closing the last READ cycle, rf_data_out is captured into rsp_rdata, rf_read_en goes 0 and the state moves to RESP.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid goes 0 and the state returns to IDLE.
- Latency, accept edge to rsp_valid high:
  - Write: WRITE_PULSE + 1 cycles.
  - Read: READ_WAIT + 1 cycles.
- Throughput: no new request is accepted until the response handshake completes. Minimum period is latency + 1 cycle.
- rf_write_en and rf_read_en are never 1 in the same cycle, in any state including across reset.
- rf address and data outputs hold their last value after an operation. Only the enables return to 0.
- rsp_ready held 0: RESP stalls indefinitely, with outputs stable and req_ready = 0.
- req_valid deasserted while not ready: ignored; there is no requirement to hold it.
- Reset mid-WRITE or mid-READ: enables drop immediately (asynchronously) and the in-flight request is discarded with no response.
- Counter: width clog2(max(WRITE_PULSE, READ_WAIT)) + 1. It loads on state entry and has no wrap-around.

Optional Feature:
- Macro: REGFILE_WRITE_VERIFY_EN.
- Defined: after WRITE, the controller enters VERIFY.
  - VERIFY drives rf_read_add = written address and rf_read_en = 1 for READ_WAIT cycles, then captures rf_data_out into rsp_rdata.
  - rsp_err = (captured != written data). The state then moves to RESP.
  - Write latency becomes WRITE_PULSE + READ_WAIT + 1 cycles.
  - The enable exclusivity rule still holds: rf_write_en is 0 before rf_read_en rises.
- Undefined: the VERIFY state is absent, rsp_err is tied 0, and write responses return rsp_rdata = 0.

Test Plan:
- Reset with the rf side driving 4'hF, release rst_n -> all outputs 0 and req_ready = 1 on the first clock.
- Write addr 2, data 4'hA, rsp_ready = 1 -> rf_write_en high for exactly 1 cycle with rf_write_add = 2 and rf_data_in = A; rsp_valid 2 cycles after accept; rsp_err = 0.
- Write addrs 0..3 with data 3, 5, 9, C, then read 3, 1 (register file model attached) -> rsp_rdata = C, then 5; read latency 2 cycles; rf_read_en and rf_write_en never both high.
- Read addr 1 with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable; req_ready = 0; a new req_valid is ignored until the handshake.
- Assert rst_n low on the second cycle of a read with READ_WAIT = 3 -> rf_read_en drops immediately, no response is produced, and the controller is in IDLE.
- With REGFILE_WRITE_VERIFY_EN and the model forcing bit 0 stuck at 0, write addr 0 data 4'h7 -> rsp_rdata = 6, rsp_err = 1, latency 3 cycles; without the macro, rsp_err = 0.
